// File: rtl/ps2_key_cmd_decoder.sv
// PS/2 keyboard receiver: scan codes -> one-cycle playback command strobes; PS2_TYPEMATIC_FILTER_EN adds held-key repeat suppression.
// Latency: key_* 2 clk after the stop-bit falling edge, frame_err 1 clk after it (or on timeout); each pulse lasts 1 clk.
// Backpressure: none; strobes are fire-and-forget, and the keyboard paces its own frames.
module ps2_key_cmd_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_d,
    output logic       key_e,
    output logic       key_b,
    output logic       key_f,
    output logic       key_r,
    output logic       frame_err,
    output logic [7:0] last_scancode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DECODE
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fe;
    logic                   din;

    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_bit, par_nxt;
    logic          brk_flag, brk_nxt;
    logic          ext_flag, ext_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [4:0]    keys_q, keys_nxt;
    logic          err_q, err_nxt;
    logic [7:0]    last_q, last_nxt;
    logic          abort;
    logic          fire;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0]    held, held_nxt;
`endif

    // Sync flops reset low so a bus already idling high at release never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fe  = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign din = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
            tmo_cnt  <= '0;
            keys_q   <= '0;
            err_q    <= 1'b0;
            last_q   <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_nxt;
            brk_flag <= brk_nxt;
            ext_flag <= ext_nxt;
            tmo_cnt  <= tmo_nxt;
            keys_q   <= keys_nxt;
            err_q    <= err_nxt;
            last_q   <= last_nxt;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held     <= held_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par_bit;
        brk_nxt     = brk_flag;
        ext_nxt     = ext_flag;
        tmo_nxt     = '0;
        keys_nxt    = '0;
        err_nxt     = 1'b0;
        last_nxt    = last_q;
        abort       = 1'b0;
        fire        = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_nxt    = held;
`endif

        // The watchdog only runs mid-frame; any falling edge restarts it.
        if (state == DATA || state == PARITY || state == STOP) begin
            if (fe)
                tmo_nxt = '0;
            else if (tmo_cnt == TW'(TIMEOUT_CYCLES))
                abort = 1'b1;
            else
                tmo_nxt = tmo_cnt + TW'(1);
        end

        case (state)
            IDLE: begin
                if (fe && !din) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (fe) begin
                    shreg_nxt   = {din, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (fe) begin
                    par_nxt   = din;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    if (din && (^{shreg, par_bit}))
                        state_nxt = DECODE;
                    else
                        abort = 1'b1;
                end
            end
            DECODE: begin
                state_nxt = IDLE;
                last_nxt  = shreg;
                if (shreg == 8'hF0) begin
                    brk_nxt = 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_nxt = 1'b1;
                end else if (brk_flag || ext_flag) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (brk_flag && shreg == held)
                        held_nxt = '0;
`endif
                    brk_nxt = 1'b0;
                    ext_nxt = 1'b0;
                end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (shreg != held) begin
                        fire     = 1'b1;
                        held_nxt = shreg;
                    end
`else
                    fire = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (fire) begin
            case (shreg)
                8'h23:   keys_nxt = 5'b00001;
                8'h24:   keys_nxt = 5'b00010;
                8'h32:   keys_nxt = 5'b00100;
                8'h2B:   keys_nxt = 5'b01000;
                8'h2D:   keys_nxt = 5'b10000;
                default: keys_nxt = 5'b00000;
            endcase
        end

        // Bad frame or stalled keyboard: drop the partial byte and any pending prefix.
        if (abort) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            brk_nxt   = 1'b0;
            ext_nxt   = 1'b0;
            tmo_nxt   = '0;
        end
    end

    assign key_d         = keys_q[0];
    assign key_e         = keys_q[1];
    assign key_b         = keys_q[2];
    assign key_f         = keys_q[3];
    assign key_r         = keys_q[4];
    assign frame_err     = err_q;
    assign last_scancode = last_q;

endmodule
